// File: rtl/alu_cmd_dispatcher.sv
// Command front-end for the single-cycle ALU: queues commands in a FIFO, issues them one
// at a time, waits for alu_done (with timeout) and returns tagged responses in order.
module alu_cmd_dispatcher #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    output logic                   alu_start,
    output logic [2:0]             alu_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    input  logic                   alu_done,
    input  logic [15:0]            alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [2:0]  OP_NOP = 3'd0;
    localparam logic [2:0]  OP_XOR = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       mem_op  [DEPTH];
    logic [7:0]       mem_a   [DEPTH];
    logic [7:0]       mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [TAG_W-1:0] tag_cnt;
    logic             push, pop;
    logic [2:0]       head_op;

    logic [TMR_W-1:0] timer, timer_nxt;
    logic [TAG_W-1:0] cur_tag, cur_tag_nxt;

    logic             alu_start_nxt;
    logic [2:0]       alu_op_nxt;
    logic [7:0]       alu_a_nxt, alu_b_nxt;
    logic             rsp_valid_nxt;
    logic [15:0]      rsp_result_nxt;
    logic             rsp_err_nxt;
    logic [TAG_W-1:0] rsp_tag_nxt;

    // No bypass: a full FIFO refuses even when a pop happens in the same cycle.
    assign cmd_ready = (count != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head_op   = mem_op[rd_ptr];

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]  <= cmd_op;
            mem_a[wr_ptr]   <= cmd_a;
            mem_b[wr_ptr]   <= cmd_b;
            mem_tag[wr_ptr] <= tag_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tag_cnt <= tag_cnt + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            cur_tag    <= '0;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            cur_tag    <= cur_tag_nxt;
            alu_start  <= alu_start_nxt;
            alu_op     <= alu_op_nxt;
            alu_a      <= alu_a_nxt;
            alu_b      <= alu_b_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_result <= rsp_result_nxt;
            rsp_err    <= rsp_err_nxt;
            rsp_tag    <= rsp_tag_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        timer_nxt      = timer;
        cur_tag_nxt    = cur_tag;
        alu_start_nxt  = 1'b0;
        alu_op_nxt     = alu_op;
        alu_a_nxt      = alu_a;
        alu_b_nxt      = alu_b;
        rsp_result_nxt = rsp_result;
        rsp_err_nxt    = rsp_err;
        rsp_tag_nxt    = rsp_tag;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_op == OP_NOP) begin
                        state_nxt = IDLE;
                    end else if (head_op <= OP_XOR) begin
                        alu_start_nxt = 1'b1;
                        alu_op_nxt    = head_op;
                        alu_a_nxt     = mem_a[rd_ptr];
                        alu_b_nxt     = mem_b[rd_ptr];
                        cur_tag_nxt   = mem_tag[rd_ptr];
                        timer_nxt     = '0;
                        state_nxt     = WAIT;
                    end else begin
                        rsp_result_nxt = '0;
                        rsp_err_nxt    = 1'b1;
                        rsp_tag_nxt    = mem_tag[rd_ptr];
                        state_nxt      = RESP;
                    end
                end
            end
            // alu_done takes priority over a coinciding timeout.
            WAIT: begin
                if (alu_done) begin
                    rsp_result_nxt = alu_result;
                    rsp_err_nxt    = 1'b0;
                    rsp_tag_nxt    = cur_tag;
                    state_nxt      = RESP;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    rsp_result_nxt = '0;
                    rsp_err_nxt    = 1'b1;
                    rsp_tag_nxt    = cur_tag;
                    state_nxt      = RESP;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        rsp_valid_nxt = (state_nxt == RESP);
    end

endmodule
